// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe: N-to-1 channel mux, fixed or round-robin select,
// feeding a single-entry registered output stage.
module rr_mux_pipe #(
  parameter int WIDTH = 64,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] gnt;
  logic [SELW-1:0] ptr_nxt;
  logic            gnt_vld;
  logic            load_en;

  assign load_en = !reset && (!out_valid || out_ready);

  // Descending scan so the index closest to ptr wins.
  always_comb begin : arb
    int idx;
    logic [SELW-1:0] ix;
    idx = 0;
    ix = '0;
    gnt = '0;
    gnt_vld = 1'b0;
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        ix = SELW'(idx);
        if (in_valid[ix]) begin
          gnt_vld = 1'b1;
          gnt = ix;
        end
      end
    end else if (int'(sel) < N) begin
      if (in_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt = sel;
      end
    end
  end

  assign ptr_nxt = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;

  always_comb begin
    in_ready = '0;
    if (load_en && gnt_vld) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= in_data[int'(gnt)*WIDTH +: WIDTH];
        out_src  <= gnt;
        if (mode) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_pipe.sv
// tb_rr_mux_pipe: scoreboard bench for rr_mux_pipe at N=4/W=64
// and N=3/W=16, directed cases plus random traffic vs a queue model.
module tb_rr_mux_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [1:0] done = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NN = (g == 0) ? 4 : 3;
    localparam int W  = (g == 0) ? 64 : 16;
    localparam int SW = $clog2(NN);

    logic            reset = 1'b1;
    logic            mode = 1'b0;
    logic            out_ready = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [NN*W-1:0] in_data = '0;
    logic [NN-1:0]   in_valid = '0;
    logic [NN-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_valid;

    logic [W+SW-1:0] sb[$];
    int mptr = 0;
    bit mov = 1'b0;
    bit armed = 1'b0;

    rr_mux_pipe #(.WIDTH(W), .N(NN)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel),
      .out_data(out_data), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready)
    );

    // Reference choice: fixed select, or first valid at/after the pointer.
    function automatic int pick(logic [NN-1:0] iv, bit md, int sl);
      if (!md) begin
        if (sl < NN) begin
          if (iv[sl]) return sl;
        end
        return -1;
      end
      for (int k = 0; k < NN; k++)
        if (iv[(mptr + k) % NN]) return (mptr + k) % NN;
      return -1;
    endfunction

    task automatic cyc(bit rst, bit md, int sl, logic [NN-1:0] iv, bit ordy);
      int gi;
      bit le;
      logic [NN-1:0] er;
      reset = rst;
      mode = md;
      sel = SW'(sl);
      in_valid = iv;
      out_ready = ordy;
      for (int i = 0; i < NN; i++)
        in_data[i*W +: W] = W'({$urandom, $urandom});
      #1;
      le = !rst && (!mov || ordy);
      gi = rst ? -1 : pick(iv, md, sl);
      er = '0;
      if (le && gi >= 0) er[gi] = 1'b1;
      check($sformatf("cfg%0d in_ready", g), 64'(in_ready), 64'(er));
      if (armed)
        check($sformatf("cfg%0d out_valid", g), 64'(out_valid), 64'(mov));
      if (rst) begin
        mov = 1'b0;
        mptr = 0;
        armed = 1'b1;
        sb.delete();
      end else if (le) begin
        mov = (gi >= 0);
        if (gi >= 0) begin
          sb.push_back({in_data[gi*W +: W], SW'(gi)});
          if (md) mptr = (gi + 1) % NN;
        end
      end
      @(negedge clk);
    endtask

    task automatic regs(string tag, bit ov, logic [W-1:0] d, int s);
      check($sformatf("cfg%0d %s out_valid", g, tag), 64'(out_valid), 64'(ov));
      check($sformatf("cfg%0d %s out_data", g, tag), 64'(out_data), 64'(d));
      check($sformatf("cfg%0d %s out_src", g, tag), 64'(out_src), 64'(s));
    endtask

    initial begin : monitor
      logic [W+SW-1:0] e;
      forever begin
        @(negedge clk);
        #2;
        if (armed && !reset && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check($sformatf("cfg%0d sb_nonempty", g), 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            check($sformatf("cfg%0d out_data", g), 64'(out_data), 64'(e[W+SW-1:SW]));
            check($sformatf("cfg%0d out_src", g), 64'(out_src), 64'(e[SW-1:0]));
          end
        end
      end
    end

    initial begin : driver
      logic [NN-1:0] all1;
      logic [NN-1:0] odd;
      logic [NN-1:0] one;
      all1 = '1;
      odd = '0;
      for (int i = 1; i < NN; i += 2) odd[i] = 1'b1;
      @(negedge clk);
      cyc(1, 0, 0, all1, 1);
      cyc(1, 1, 0, all1, 1);
      regs("reset", 0, '0, 0);
      repeat (6) cyc(0, 1, 0, all1, 1);
      cyc(1, 1, 0, all1, 1);
      repeat (5) cyc(0, 1, 0, odd, 1);
      one = '0;
      one[NN-2] = 1'b1;
      repeat (4) cyc(0, 0, NN - 2, one, 0);
      repeat (2) cyc(0, 0, NN - 2, one, 1);
      repeat (2) cyc(0, 0, (1 << SW) - 1, all1, 1);
      one = '0;
      one[NN-1] = 1'b1;
      cyc(0, 1, 0, one, 1);
      repeat (2) cyc(0, 1, 0, all1, 1);
      repeat (2) cyc(0, 0, 0, all1, 0);
      cyc(1, 0, 0, all1, 0);
      regs("stall_reset", 0, '0, 0);
      repeat (400)
        cyc($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, (1 << SW) - 1)), NN'($urandom),
            $urandom_range(0, 3) != 0);
      repeat (3) cyc(0, 0, 0, '0, 1);
      check($sformatf("cfg%0d sb_drained", g), 64'(sb.size()), 64'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && done != 2'b11; i++) @(posedge clk);
    if (done != 2'b11) begin
      total++;
      bad++;
      $display("FAIL timeout: done=%b expected 11", done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_pipe.md
RR_MUX_PIPE -- requirements
Module: rr_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 64, bit width of each data channel.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Local parameter SELW = $clog2(N), width of select and source indices.
REQ-004 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port reset  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-006 Port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid  input  N  channel i offers a word.
REQ-008 Port in_ready  output  N  channel i word accepted this cycle.
REQ-009 Port mode  input  1  0 = fixed select via sel; 1 = round-robin.
REQ-010 Port sel  input  SELW  channel index used when mode = 0.
REQ-011 Port out_data  output  WIDTH  registered output word.
REQ-012 Port out_src  output  SELW  index of the channel that supplied out_data.
REQ-013 Port out_valid  output  1  out_data/out_src hold a word.
REQ-014 Port out_ready  input  1  downstream accepts the output word this cycle.

Function
REQ-015 Transfer on any port SHALL occur only in a cycle where valid and ready are both 1.
REQ-016 Output stage SHALL be a single register entry; load_en = !out_valid || out_ready.
REQ-017 Mode 0: grant SHALL be sel when sel < N and in_valid[sel] = 1; otherwise no grant.
REQ-018 Mode 0 with sel >= N SHALL grant nothing; all in_ready = 0.
REQ-019 Mode 1: grant SHALL be the first index with in_valid = 1, searching ptr, ptr+1, ..., wrapping mod N.
REQ-020 in_ready[i] SHALL be 1 iff load_en = 1 and grant = i; at most one in_ready bit high per cycle.
REQ-021 in_ready SHALL be combinational from in_valid, mode, sel, ptr, out_valid and out_ready; it is not registered.
REQ-022 On a grant with load_en: out_data <= granted word, out_src <= grant, out_valid <= 1 at next edge (latency 1 cycle).
REQ-023 With load_en = 1 and no grant: out_valid <= 0 at next edge; out_data and out_src hold their values.
REQ-024 While out_valid = 1 and out_ready = 0: out_data, out_src and out_valid SHALL hold; all in_ready = 0.
REQ-025 Simultaneous drain and refill (out_valid = 1, out_ready = 1, grant present) SHALL load the new word with no bubble; sustained throughput 1 word/cycle.
REQ-026 Round-robin pointer ptr (SELW bits) SHALL update to (grant+1) mod N only on an accepted transfer in mode 1.
REQ-027 ptr SHALL hold in mode 0 and on cycles without an accepted transfer.
REQ-028 Wrap-around: grant = N-1 SHALL set ptr to 0, including when N is not a power of 2.
REQ-029 A mode or sel change SHALL take effect in the same cycle's arbitration; a word already in the output register is unaffected.
REQ-030 An input whose in_valid drops before acceptance SHALL lose nothing: no state retains unaccepted input data.

Reset
REQ-031 When reset = 1 at posedge: out_valid <= 0, out_data <= 0, out_src <= 0, ptr <= 0.
REQ-032 While reset = 1, in_ready SHALL be all 0 and no transfer SHALL be counted.
REQ-033 Reset asserted mid-stall SHALL discard the held output word; first post-reset round-robin grant starts search at index 0.

Verification
REQ-034 N=4, mode 1, all in_valid = 1, out_ready = 1, data_i = 0x10+i -> out_src 0,1,2,3,0 on consecutive cycles, first out_valid one cycle after reset release.
REQ-035 N=4, mode 1, in_valid = 4'b1010, ptr = 0 -> grants 1,3,1,3; ptr after grant 3 is 0.
REQ-036 Mode 0, sel = 2, in_valid[2] = 1, out_ready = 0 for 3 cycles -> out_data = data_2 held stable, in_ready = 0 throughout stall, transfer completes on first out_ready = 1.
REQ-037 N=3, mode 0, sel = 3 with all in_valid = 1 -> in_ready = 3'b000, out_valid falls to 0.
REQ-038 N=3, mode 1, only in_valid[2] = 1 -> grant 2, ptr wraps to 0; then all valid -> next grant 0.
REQ-039 Reset asserted while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, out_data = 0, out_src = 0.
